// File: rtl/tdc_dll_phase_gen.sv
// rtl/tdc_dll_phase_gen.sv - 32-tap rotating thermometer phase source with integrity check and lock FSM
module tdc_dll_phase_gen #(
  parameter int N_PHASE     = 32,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       inj_flip,
  input  logic                       err_clr,
  output logic [N_PHASE-1:0]         DLL_Phase,
  output logic                       phase_clk,
  output logic [$clog2(N_PHASE)-1:0] phase_idx,
  output logic                       dll_lock,
  output logic                       dll_err
);

  localparam int IDX_W = $clog2(N_PHASE);
  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [N_PHASE-1:0] SEED = {{(N_PHASE/2){1'b1}}, {(N_PHASE/2){1'b0}}};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_PHASE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  logic [N_PHASE-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   lock_cnt_q;
  logic               lock_q;
  logic               err_q;

  logic [IDX_W:0]     ones;
  logic [IDX_W:0]     falls;
  logic               bad;
  logic [N_PHASE-1:0] rot;

  // Integrity check: half the taps high and a single contiguous run of ones around the ring
  always_comb begin
    ones  = '0;
    falls = '0;
    for (int i = 0; i < N_PHASE; i++) begin
      ones = ones + {{IDX_W{1'b0}}, phase_q[i]};
      if (phase_q[i] && !phase_q[(i + 1) % N_PHASE]) begin
        falls = falls + {{IDX_W{1'b0}}, 1'b1};
      end
    end
    bad = !((ones == (IDX_W+1)'(N_PHASE/2)) && (falls == (IDX_W+1)'(1)));
  end

  // Next ring value: reseed on corruption, otherwise rotate or hold with optional bit-0 fault
  always_comb begin
    rot     = {phase_q[0], phase_q[N_PHASE-1:1]};
    phase_d = phase_q;
    idx_d   = idx_q;
    if (bad) begin
      phase_d = SEED;
      idx_d   = '0;
    end else if (en) begin
      phase_d = {rot[N_PHASE-1:1], rot[0] ^ inj_flip};
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      phase_d = {phase_q[N_PHASE-1:1], phase_q[0] ^ inj_flip};
    end
  end

  // Ring registers, lock FSM and sticky error flag; corruption overrides every FSM transition
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      phase_q    <= SEED;
      idx_q      <= '0;
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      if (bad) begin
        err_q      <= 1'b1;
        lock_cnt_q <= '0;
        lock_q     <= 1'b0;
        state_q    <= en ? WARMUP : IDLE;
      end else begin
        if (err_clr) begin
          err_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (en) begin
              state_q    <= WARMUP;
              lock_cnt_q <= '0;
            end
          end
          WARMUP: begin
            if (!en) begin
              state_q <= IDLE;
            end else if (lock_cnt_q == CNT_LAST) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
            end else begin
              lock_cnt_q <= lock_cnt_q + CNT_W'(1);
            end
          end
          LOCKED: begin
            if (!en) begin
              state_q <= IDLE;
              lock_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DLL_Phase = phase_q;
  assign phase_clk = phase_q[0];
  assign phase_idx = idx_q;
  assign dll_lock  = lock_q;
  assign dll_err   = err_q;

endmodule

// File: doc/tdc_dll_phase_gen.md
Name: tdc_dll_phase_gen

Overview:
Upstream phase source for tdc_top. It generates the 32-tap DLL_Phase bus, a circulating thermometer pattern of 16 ones and 16 zeros that rotates one tap per clk_i edge. Tap 0 (phase_clk) is the TDC counter clock (clk5). The block also checks pattern integrity every cycle, reseeds the ring on corruption, and reports lock and error status to core logic, which must not issue TDC_start before lock.

Parameters:
N_PHASE, 32, number of phase taps; must be even, ≥4.
LOCK_CYCLES, 64, consecutive error-free rotations in WARMUP required before lock; ≥2.

Ports:
clk_i  in  1  ring clock; one tap advance per rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  run enable; 0 = hold pattern.
inj_flip  in  1  verification fault injection; inverts bit 0 of the next loaded value.
err_clr  in  1  clears sticky dll_err.
DLL_Phase  out  N_PHASE  phase tap bus to tdc_top.
phase_clk  out  1  equals DLL_Phase[0].
phase_idx  out  clog2(N_PHASE)  rotation count modulo N_PHASE; 0 = seed alignment.
dll_lock  out  1  ring locked, taps usable.
dll_err  out  1  sticky integrity error flag.

Behaviour:
- Reset (rst=0, async):
  - DLL_Phase = SEED, where SEED = upper N/2 bits 1, lower N/2 bits 0 (0xFFFF0000 for N=32).
  - phase_idx=0, dll_lock=0, dll_err=0, lock_cnt=0, state=IDLE.
- Rotation: DLL_Phase <= {DLL_Phase[0], DLL_Phase[N-1:1]} (rotate right); phase_idx <= phase_idx+1, wrapping N-1 -> 0.
- Checker (combinational on the current DLL_Phase register):
  - valid iff popcount == N/2 AND exactly one circular index i has P[i]=1 and P[(i+1) mod N]=0.
  - bad = !valid.
- Next-value priority on each clk_i edge:
  1. bad: DLL_Phase<=SEED, phase_idx<=0, dll_err<=1, lock_cnt<=0, dll_lock<=0, state<=(en ? WARMUP : IDLE). inj_flip is ignored on this edge.
  2. else en=1: rotate; if inj_flip, bit 0 of the rotated value is inverted.
  3. else en=0: hold DLL_Phase and phase_idx; if inj_flip, bit 0 of the held value is inverted.
- Error latency: corrupt value loaded at edge k is flagged during cycle k and replaced by SEED at edge k+1. dll_err is high from edge k+1.
- FSM states IDLE, WARMUP, LOCKED; bad overrides every transition below.
  - IDLE: en=1 -> WARMUP, lock_cnt<=0; this edge also rotates.
  - WARMUP:
    - en=0 -> IDLE.
    - en=1: lock_cnt++ per edge.
    - If lock_cnt==LOCK_CYCLES-1 at an en=1 edge -> LOCKED, dll_lock<=1.
    - dll_lock therefore rises at the (LOCK_CYCLES+1)-th consecutive en=1 edge counted from IDLE.
  - LOCKED: en=0 -> IDLE, dll_lock<=0 on the same edge.
- dll_lock is 1 only in LOCKED and is registered.
- dll_err clears on an err_clr=1 edge. If bad and err_clr coincide, set wins and dll_err stays 1.
- phase_clk is a direct wire from DLL_Phase[0]: period N clk_i cycles, 50% duty while en=1.
- Reset asserted mid-rotation returns immediately to SEED and IDLE. No output glitches beyond the async reset transition.
- lock_cnt width is clog2(LOCK_CYCLES); it must not wrap in WARMUP.

Test Plan:
1. Reset held, then released with en=0 -> DLL_Phase=0xFFFF0000, phase_idx=0, dll_lock=0, dll_err=0, value held for 100 clk_i cycles.
2. en=1 for 32 edges -> after edge 1 DLL_Phase=0x7FFF8000; after edge 32 DLL_Phase=0xFFFF0000 and phase_idx=0; phase_clk high 16 cycles and low 16 cycles.
3. LOCK_CYCLES=64, en=1 from IDLE -> dll_lock=0 after edge 64 and 1 after edge 65. Drop en -> dll_lock=0 on that edge and pattern frozen. Re-raise en -> relock after a further 65 edges.
4. Locked, pulse inj_flip one cycle -> corrupt value present one cycle, then DLL_Phase=0xFFFF0000, phase_idx=0, dll_err=1, dll_lock=0; relock 64 edges later (WARMUP entered directly); dll_err remains 1.
5. err_clr pulse with no fault -> dll_err=0. err_clr in the same cycle as a detected bad pattern -> dll_err stays 1.
6. Async rst pulse mid-rotation (phase_idx=13, locked) -> outputs return to reset values immediately with no clk_i edge. After release with en=1, behaviour is identical to scenario 3.
